// File: rtl/pipe_pkg.sv
// Shared constants, stage control payload and sizing helper for the pipe_stage_chain slice.
package pipe_pkg;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 128;
    localparam int unsigned DEPTH_MIN = 1;
    localparam int unsigned DEPTH_MAX = 16;

    // Per-stage control: load a new entry and/or give up the current one.
    typedef struct packed {
        logic load;
        logic unload;
    } stage_ctrl_t;

    // Bits needed to count 0..depth live entries.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid bit plus payload, with load/unload and flush control.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  stage_ctrl_t      ctrl,
    input  logic [WIDTH-1:0] d_in,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    // Payload is left untouched by flush and by a plain drain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else if (flush) begin
            v <= 1'b0;
        end else if (ctrl.load) begin
            v <= 1'b1;
            d <= d_in;
        end else if (ctrl.unload) begin
            v <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic register chain with bubble collapsing, global stall/flush and live-entry count.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            stall,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int unsigned CW = count_width(DEPTH);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("pipe_stage_chain: DEPTH out of range 1..16");
    end
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("pipe_stage_chain: WIDTH out of range 1..128");
    end

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] src_v;
    logic [DEPTH-1:0] free;
    logic [DEPTH-1:0] next_v;
    logic [DEPTH:0]   adv;
    logic [CW-1:0]    count_next;
    logic             go;

    // Valid bit feeding each stage: in_valid for stage 0, v[i-1] otherwise.
    assign src_v = DEPTH'({v, in_valid});

    // adv[i] loads stage i; adv[i+1] empties it. Resolved from the output end backwards.
    always_comb begin
        go         = !stall && !flush;
        adv        = '0;
        free       = '0;
        next_v     = '0;
        count_next = '0;
        adv[DEPTH] = v[DEPTH-1] && out_ready && go;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free[i]    = !v[i] || adv[i+1];
            adv[i]     = src_v[i] && free[i] && go;
            next_v[i]  = !flush && (adv[i] || (v[i] && !adv[i+1]));
            count_next = count_next + CW'(next_v[i]);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        stage_ctrl_t      ctrl;
        logic [WIDTH-1:0] d_in;

        assign ctrl.load   = adv[i];
        assign ctrl.unload = adv[i+1];

        if (i == 0) begin : g_first
            assign d_in = in_data;
        end else begin : g_next
            assign d_in = d[i-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .ctrl  (ctrl),
            .d_in  (d_in),
            .v     (v[i]),
            .d     (d[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign in_ready  = free[0] && go;
    assign out_valid = v[DEPTH-1] && go;
    assign out_data  = d[DEPTH-1];

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the payload width in bits; legal range 1..128.
REQ-002 Parameter DEPTH, default 3, SHALL set the number of register stages; legal range 1..16; elaboration SHALL fail outside this range.
REQ-003 Parameter RESET_VAL, default 0 (WIDTH bits), SHALL set the payload value loaded at reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 stall  in  1  global freeze; high holds all stages.
REQ-007 flush  in  1  high kills all in-flight entries.
REQ-008 in_valid  in  1  upstream offers in_data.
REQ-009 in_ready  out  1  chain accepts in_data this cycle.
REQ-010 in_data  in  WIDTH  upstream payload.
REQ-011 out_valid  out  1  last stage holds a live entry.
REQ-012 out_ready  in  1  downstream accepts out_data.
REQ-013 out_data  out  WIDTH  last-stage payload.
REQ-014 count  out  $clog2(DEPTH+1)  number of live entries.

Function
REQ-015 Each stage i SHALL hold a valid bit v[i] and a WIDTH-bit payload d[i]; stage 0 is the input side, stage DEPTH-1 drives out_data.
REQ-016 Stage DEPTH-1 SHALL drain when out_valid and out_ready are both high.
REQ-017 Stage i SHALL be free when v[i] is low or stage i drains (i = DEPTH-1) or advances into stage i+1 (i < DEPTH-1).
REQ-018 Stage i > 0 SHALL load from stage i-1 when v[i-1] is high, stage i is free, stall is low and flush is low; stage 0 SHALL load in_data when in_valid and in_ready are both high.
REQ-019 in_ready SHALL be combinational: stage 0 free, stall low, flush low.
REQ-020 out_valid SHALL equal v[DEPTH-1] AND NOT stall AND NOT flush; out_data SHALL equal d[DEPTH-1] at all times.
REQ-021 A stage that neither loads nor drains SHALL retain v and d; a stage that drains without loading SHALL clear v and retain d.
REQ-022 Bubbles SHALL collapse: an entry SHALL advance into any empty downstream stage every unstalled cycle, so back-to-back traffic with out_ready high sustains one transfer per cycle.
REQ-023 Latency SHALL be DEPTH cycles: an entry accepted at edge k SHALL appear with out_valid high after edge k+DEPTH-1 when unobstructed.
REQ-024 stall high SHALL freeze all v and d, force in_ready and out_valid low, and lose no entry.
REQ-025 flush high SHALL clear every v[i] at the next edge, accept no input, drain no output (out_valid low), and leave d unchanged; flush SHALL take priority over stall.
REQ-026 count SHALL equal the registered population count of v[], updated every edge; count SHALL reach DEPTH when full and 0 when empty.
REQ-027 With count = DEPTH and out_ready high, the chain SHALL accept a new input in the same cycle it drains (in_ready high).

Reset
REQ-028 On a clk edge with reset low, all v[i] SHALL clear, all d[i] SHALL load RESET_VAL and count SHALL become 0, overriding stall, flush and all handshakes.
REQ-029 Reset asserted mid-traffic SHALL discard all entries; in_ready SHALL be high on the first cycle after reset release if stall and flush are low.

Structure
REQ-030 Package pipe_pkg SHALL hold the count-width function and the DEPTH/WIDTH range constants.
REQ-031 One sub-module pipe_stage (one v/d slot with load/drain control) SHALL be instantiated DEPTH times by a generate loop.

Verification
REQ-032 DEPTH=3: stream 0x11,0x22,0x33,0x44 on consecutive cycles, out_ready high -> outputs appear in order, first after edge 3, one per cycle, count steady at 3.
REQ-033 Fill with 0xA,0xB,0xC, out_ready low -> count=3, in_ready low; then raise out_ready with in_valid high (0xD) -> 0xA drains and 0xD accepted the same cycle.
REQ-034 Two entries in flight, stall high 4 cycles -> in_ready and out_valid low, count constant; stall low -> both entries emerge unchanged.
REQ-035 Full chain, flush and stall high together with in_valid high -> next cycle count=0, out_valid low, the offered input not accepted.
REQ-036 Reset low mid-stream with out_ready low -> count=0, out_data=RESET_VAL, no stale entry emitted after release.
REQ-037 DEPTH=1, WIDTH=8: 0xFF accepted, out_ready high -> out_valid after one edge, in_ready high every cycle.
